// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states and
// the STEP legality check. Optional rotate support is enabled by SHIFTER_ROTATE_EN.
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // STEP must be a power of two in 1..xlen.
  function automatic bit step_legal(input int xlen, input int step);
    return (step >= 1) && (step <= xlen) && ((step & (step - 1)) == 0);
  endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-step shifter: shifts acc_i by k_i (0..STEP) per op_i.
// Rotate feedback exists only when SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int KW = $clog2(STEP) + 1
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [KW-1:0]   k_i,
  input  logic [1:0]      op_i,
  output logic [XLEN-1:0] res_o
);

`ifdef SHIFTER_ROTATE_EN
  logic [2*XLEN-1:0] dbl_s;
  assign dbl_s = {acc_i, acc_i} << k_i;
`endif

  always_comb begin
    res_o = acc_i;
    case (op_i)
      OP_SLL: res_o = acc_i << k_i;
      OP_SRL: res_o = acc_i >> k_i;
      OP_SRA: res_o = $signed(acc_i) >>> k_i;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: res_o = dbl_s[2*XLEN-1:XLEN];
`else
      // Without rotate support op 10 behaves as SLL.
      OP_ROL: res_o = acc_i << k_i;
`endif
      default: res_o = acc_i << k_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA (optional ROL via SHIFTER_ROTATE_EN) unit shifting up
// to STEP bits per clock, with valid/ready handshakes on input and output.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [SHW-1:0]  in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  // An illegal STEP falls back to single-bit shifting.
  localparam int STEP_EFF = step_legal(XLEN, STEP) ? STEP : 1;
  localparam int KW = $clog2(STEP_EFF) + 1;
  localparam logic [SHW:0]  STEP_W = (SHW + 1)'(STEP_EFF);
  localparam logic [KW-1:0] STEP_K = KW'(STEP_EFF);

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [1:0]      op_q, op_d;

  logic            accept_s;
  logic [SHW:0]    rem_ext_s;
  logic [KW-1:0]   k_s;
  logic [XLEN-1:0] step_res_s;

  assign accept_s  = (state_q == IDLE) && in_valid;
  assign rem_ext_s = {1'b0, rem_q};
  assign k_s       = (rem_ext_s >= STEP_W) ? STEP_K : rem_ext_s[KW-1:0];

  shift_step #(
    .XLEN(XLEN),
    .STEP(STEP_EFF)
  ) u_step (
    .acc_i(acc_q),
    .k_i  (k_s),
    .op_i (op_q),
    .res_o(step_res_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = (in_shamt == '0) ? DONE : SHIFT;
             else state_d = IDLE;
      // Leave SHIFT on the edge that consumes the last remaining bits.
      SHIFT: if (rem_ext_s <= STEP_W) state_d = DONE;
             else state_d = SHIFT;
      DONE:  if (out_ready) state_d = IDLE;
             else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    op_d  = op_q;
    if (accept_s) begin
      acc_d = in_data;
      rem_d = in_shamt;
      op_d  = in_op;
    end else if (state_q == SHIFT) begin
      acc_d = step_res_s;
      rem_d = rem_q - SHW'(k_s);
    end else begin
      acc_d = acc_q;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = acc_q;
  end

endmodule
